// File: rtl/serial_pattern_pkg.sv
// rtl/serial_pattern_pkg.sv - shared state type and defaults for the serial pattern transmitter
package serial_pattern_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int GAP_CYC_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pattern_shreg.sv
// rtl/pattern_shreg.sv - captured frame, MSB-aligned shift register and bit counter
module pattern_shreg #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              reload,
  input  logic              shift,
  input  logic [DATA_W-1:0] pattern,
  input  logic [CNT_W-1:0]  len,
  output logic              last,
  output logic              bit_out
);

  logic [DATA_W-1:0] frame_q, frame_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_eff;

  // Zero and oversize lengths both mean a full-width frame
  always_comb begin
    len_eff = len;
    if ((len == '0) || (len > CNT_W'(DATA_W))) begin
      len_eff = CNT_W'(DATA_W);
    end
  end

  // Working register is cleared whenever it is not feeding x, so its MSB doubles as the x flop
  always_comb begin
    frame_d = frame_q;
    len_d   = len_q;
    sh_d    = '0;
    cnt_d   = '0;
    if (load) begin
      frame_d = pattern;
      len_d   = len_eff;
      sh_d    = pattern << (CNT_W'(DATA_W) - len_eff);
      cnt_d   = len_eff - 1'b1;
    end else if (reload) begin
      sh_d  = frame_q << (CNT_W'(DATA_W) - len_q);
      cnt_d = len_q - 1'b1;
    end else if (shift) begin
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Frame capture, shift and bit-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      len_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      frame_q <= frame_d;
      len_q   <= len_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last    = (cnt_q == '0);
  assign bit_out = sh_q[DATA_W-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - MSB-first serial frame transmitter with repeat, gap and stop control
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int GAP_CYC = GAP_CYC_DEF,
  localparam int CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  input  logic [CNT_W-1:0]  len,
  input  logic              repeat_en,
  input  logic              stop,
  output logic              x,
  output logic              x_valid,
  output logic              busy,
  output logic              done
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e             state_q, state_d;
  logic               stop_pend_q, stop_pend_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               x_valid_q, busy_q, done_q;
  logic               load, reload, shift, last;

  pattern_shreg #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .reload  (reload),
    .shift   (shift),
    .pattern (pattern),
    .len     (len),
    .last    (last),
    .bit_out (x)
  );

  // Next state, stop tracking, gap counting and shift-register control
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    gap_cnt_d   = gap_cnt_q;
    load        = 1'b0;
    reload      = 1'b0;
    shift       = 1'b0;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (stop) stop_pend_d = 1'b1;
        if (!last) begin
          shift = 1'b1;
        end else if (stop_pend_q || stop) begin
          state_d = DONE;
        end else if (repeat_en && (GAP_CYC > 0)) begin
          state_d   = GAP;
          gap_cnt_d = GAP_W'(GAP_CYC - 1);
        end else if (repeat_en) begin
          reload = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      GAP: begin
        if (stop) begin
          state_d = DONE;
        end else if (gap_cnt_q == '0) begin
          reload  = 1'b1;
          state_d = SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      DONE: begin
        stop_pend_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered status outputs, all decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stop_pend_q <= 1'b0;
      gap_cnt_q   <= '0;
      x_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      gap_cnt_q   <= gap_cnt_d;
      x_valid_q   <= (state_d == SHIFT);
      busy_q      <= (state_d == SHIFT) || (state_d == GAP);
      done_q      <= (state_d == DONE);
    end
  end

  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - scoreboard bench for serial_pattern_tx
module tb_serial_pattern_tx;

  localparam int T0 = 0, T1 = 1, TGAP = 2, TDONE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic       repeat_en = 1'b0;
  logic       stop = 1'b0;
  logic       x2, xv2, busy2, done2;
  logic       x0, xv0, busy0, done0;
  logic       sel0 = 1'b0;
  logic       m_x, m_xv, m_busy, m_done;
  logic       det_en = 1'b0;
  logic [3:0] det_sh = '0;
  logic [15:0] det_exp;

  int exp_q[$];
  int det_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  serial_pattern_tx #(.DATA_W(8), .GAP_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .len(len),
    .repeat_en(repeat_en), .stop(stop),
    .x(x2), .x_valid(xv2), .busy(busy2), .done(done2)
  );

  serial_pattern_tx #(.DATA_W(8), .GAP_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .len(len),
    .repeat_en(repeat_en), .stop(stop),
    .x(x0), .x_valid(xv0), .busy(busy0), .done(done0)
  );

  assign m_x    = sel0 ? x0    : x2;
  assign m_xv   = sel0 ? xv0   : xv2;
  assign m_busy = sel0 ? busy0 : busy2;
  assign m_done = sel0 ? done0 : done2;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, input int act);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got token %0d, expected nothing", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // Monitor: every observed output event is matched against the scoreboard queue
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (m_xv) begin
        pop_chk("bit", int'(m_x));
        if (det_en) begin
          det_sh = {det_sh[2:0], m_x};
          if (det_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL det: got %0d, expected nothing", int'(det_sh == 4'b1011));
          end else begin
            check("det", int'(det_sh == 4'b1011), det_q.pop_front());
          end
        end
      end else begin
        check("x_idle_zero", int'(m_x), 0);
        if (m_busy) pop_chk("gap", TGAP);
      end
      if (m_done) begin
        check("done_busy", int'(m_busy), 0);
        pop_chk("done", TDONE);
      end
    end
  end

  task automatic push_frame(input logic [7:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(int'(pat[i]));
  endtask

  task automatic start_frame(input logic [7:0] pat, input logic [3:0] ln, input logic rep);
    @(posedge clk); #1;
    pattern = pat; len = ln; repeat_en = rep; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pattern = ~pat; len = 4'd1;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0) && (cyc < 200)) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_x",  int'(x2), 0);
    check("rst_xv", int'(xv2), 0);
    check("rst_busy", int'(busy2), 0);
    check("rst_done", int'(done2), 0);
    check("rst_xv0", int'(xv0), 0);

    // single 8-bit frame, start accepted at the first edge after reset release
    push_frame(8'b0100_1011, 8);
    exp_q.push_back(TDONE);
    @(negedge clk);
    rst_n = 1'b1;
    pattern = 8'b0100_1011; len = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pattern = 8'h00;
    check("first_latency_xv", int'(xv2), 1);
    check("first_latency_x",  int'(x2), 0);
    drain("single");

    // short frame
    push_frame(8'hA5, 3);
    exp_q.push_back(TDONE);
    start_frame(8'hA5, 4'd3, 1'b0);
    drain("len3");

    // len 0 means full width; mid-frame input changes and start are ignored
    push_frame(8'h3C, 8);
    exp_q.push_back(TDONE);
    start_frame(8'h3C, 4'd0, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; pattern = 8'hFF; len = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    drain("len0");

    // oversize len clamps; start during the DONE cycle is not queued
    push_frame(8'hC3, 8);
    exp_q.push_back(TDONE);
    start_frame(8'hC3, 4'd12, 1'b0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!m_done && (cyc < 50));
    check("done_seen", int'(m_done), 1);
    #1;
    start = 1'b1; pattern = 8'hFF; len = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    drain("len12");

    // repeat with two gap cycles, stop during the second frame
    push_frame(8'h0D, 4);
    exp_q.push_back(TGAP); exp_q.push_back(TGAP);
    push_frame(8'h0D, 4);
    exp_q.push_back(TDONE);
    start_frame(8'h0D, 4'd4, 1'b1);
    repeat (7) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    drain("repeat_gap");
    repeat_en = 1'b0;

    // stop in the gap ends at once
    push_frame(8'h0D, 4);
    exp_q.push_back(TGAP);
    exp_q.push_back(TDONE);
    start_frame(8'h0D, 4'd4, 1'b1);
    repeat (4) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    drain("stop_in_gap");
    repeat_en = 1'b0;

    // back-to-back repeat with no gap
    sel0 = 1'b1;
    push_frame(8'h0D, 4);
    push_frame(8'h0D, 4);
    exp_q.push_back(TDONE);
    start_frame(8'h0D, 4'd4, 1'b1);
    repeat (5) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    drain("repeat_nogap");
    repeat_en = 1'b0;
    repeat (20) @(posedge clk);
    #1 sel0 = 1'b0;

    // asynchronous reset after the third bit aborts without done
    push_frame(8'hFF, 8);
    exp_q.push_back(TDONE);
    start_frame(8'hFF, 4'd8, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_x",    int'(x2), 0);
    check("abort_xv",   int'(xv2), 0);
    check("abort_busy", int'(busy2), 0);
    check("abort_done", int'(done2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_idle_busy", int'(busy2), 0);

    // loopback into a 1011 detector over four frames
    det_exp = 16'b0000_0001_0000_0000;
    det_sh = '0;
    det_en = 1'b1;
    begin
      logic [7:0] frames [4];
      frames[0] = 8'h04; frames[1] = 8'h0B; frames[2] = 8'h03; frames[3] = 8'h05;
      for (int f = 0; f < 4; f++) begin
        push_frame(frames[f], 4);
        exp_q.push_back(TDONE);
        for (int i = 0; i < 4; i++) det_q.push_back(int'(det_exp[15 - (4 * f + i)]));
        start_frame(frames[f], 4'd4, 1'b0);
        drain("loopback");
      end
    end
    det_en = 1'b0;
    check("det_drain", det_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
